// File: rtl/pipe_ctrl.sv
// Pipeline hazard and data-memory wait controller for a 5-stage pipeline.
// Resolves load-use stalls, branch/jump flushes and memory-wait freezes; faults on memory timeout.
module pipe_ctrl #(
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk_i,
  input  logic             start_i,
  input  logic             ID_EX_MemRead_i,
  input  logic [4:0]       ID_EX_RTaddr_i,
  input  logic [4:0]       IF_ID_RSaddr_i,
  input  logic [4:0]       IF_ID_RTaddr_i,
  input  logic             Branch_i,
  input  logic             Eq_i,
  input  logic             Jump_i,
  input  logic             EX_MEM_MemRead_i,
  input  logic             EX_MEM_MemWrite_i,
  input  logic             dmem_ack_i,
  output logic             dmem_req_o,
  output logic             PCWrite_o,
  output logic             IF_ID_Write_o,
  output logic             IF_Flush_o,
  output logic             NOP_o,
  output logic             ID_EX_Write_o,
  output logic             EX_MEM_Write_o,
  output logic             MEM_WB_Bubble_o,
  output logic             fault_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  localparam int unsigned WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {RUN, MEM_WAIT, FAULT} state_t;

  state_t            r_state;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic [CNT_W-1:0]  r_stall_cnt;

  logic w_load_use;
  logic w_transfer;
  logic w_mem_req;
  logic w_req;
  logic w_freeze;
  logic w_fault;

  assign w_load_use = ID_EX_MemRead_i && (ID_EX_RTaddr_i != 5'd0) &&
                      ((ID_EX_RTaddr_i == IF_ID_RSaddr_i) || (ID_EX_RTaddr_i == IF_ID_RTaddr_i));
  assign w_transfer = (Branch_i & Eq_i) | Jump_i;
  assign w_mem_req  = EX_MEM_MemRead_i | EX_MEM_MemWrite_i;

  // Same-cycle control outputs; freeze outranks load-use, which outranks a taken transfer.
  always_comb begin
    w_req           = 1'b0;
    w_freeze        = 1'b0;
    w_fault         = 1'b0;
    dmem_req_o      = 1'b0;
    PCWrite_o       = 1'b0;
    IF_ID_Write_o   = 1'b0;
    IF_Flush_o      = 1'b0;
    NOP_o           = 1'b0;
    ID_EX_Write_o   = 1'b0;
    EX_MEM_Write_o  = 1'b0;
    MEM_WB_Bubble_o = 1'b0;
    fault_o         = 1'b0;
    case (r_state)
      RUN: begin
        w_req    = w_mem_req;
        w_freeze = w_mem_req & ~dmem_ack_i;
      end
      MEM_WAIT: begin
        w_req    = 1'b1;
        w_freeze = ~dmem_ack_i;
      end
      default: begin
        w_freeze = 1'b1;
        w_fault  = 1'b1;
      end
    endcase
    if (start_i) begin
      dmem_req_o = w_req;
      fault_o    = w_fault;
      if (w_freeze) begin
        MEM_WB_Bubble_o = 1'b1;
      end else begin
        PCWrite_o      = ~w_load_use;
        IF_ID_Write_o  = ~w_load_use;
        NOP_o          = w_load_use;
        IF_Flush_o     = w_transfer & ~w_load_use;
        ID_EX_Write_o  = 1'b1;
        EX_MEM_Write_o = 1'b1;
      end
    end
  end

  // FSM, wait counter and saturating stall counter.
  always_ff @(posedge clk_i or negedge start_i) begin
    if (!start_i) begin
      r_state     <= RUN;
      r_wait_cnt  <= '0;
      r_stall_cnt <= '0;
    end else begin
      case (r_state)
        RUN: begin
          if (w_mem_req && !dmem_ack_i) begin
            r_state    <= MEM_WAIT;
            r_wait_cnt <= '0;
          end
        end
        MEM_WAIT: begin
          if (dmem_ack_i) begin
            r_state <= RUN;
          end else if (r_wait_cnt == WAIT_W'(TIMEOUT - 1)) begin
            r_state <= FAULT;
          end else begin
            r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
          end
        end
        FAULT: begin
          r_state <= FAULT;
        end
        default: begin
          r_state <= RUN;
        end
      endcase
      if (!PCWrite_o && (r_stall_cnt != {CNT_W{1'b1}})) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
    end
  end

  assign stall_cnt_o = r_stall_cnt;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl (TIMEOUT=4, CNT_W=4): expected control vectors are queued
// as each cycle's stimulus is applied and compared on the following falling edge.
module tb_pipe_ctrl;

  // {dmem_req, PCWrite, IF_ID_Write, IF_Flush, NOP, ID_EX_Write, EX_MEM_Write, MEM_WB_Bubble, fault}
  localparam logic [8:0] E_RST  = 9'b000000000;
  localparam logic [8:0] E_IDLE = 9'b011001100;
  localparam logic [8:0] E_LU   = 9'b000011100;
  localparam logic [8:0] E_XFER = 9'b011101100;
  localparam logic [8:0] E_FRZ  = 9'b100000010;
  localparam logic [8:0] E_REQ  = 9'b111001100;
  localparam logic [8:0] E_FLT  = 9'b000000011;

  logic       clk_i = 1'b0;
  logic       start_i;
  logic       ID_EX_MemRead_i;
  logic [4:0] ID_EX_RTaddr_i;
  logic [4:0] IF_ID_RSaddr_i;
  logic [4:0] IF_ID_RTaddr_i;
  logic       Branch_i, Eq_i, Jump_i;
  logic       EX_MEM_MemRead_i, EX_MEM_MemWrite_i, dmem_ack_i;
  logic       dmem_req_o, PCWrite_o, IF_ID_Write_o, IF_Flush_o, NOP_o;
  logic       ID_EX_Write_o, EX_MEM_Write_o, MEM_WB_Bubble_o, fault_o;
  logic [3:0] stall_cnt_o;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [3:0]  exp_stall = 4'd0;
  logic [12:0] exp_q[$];

  pipe_ctrl #(.TIMEOUT(4), .CNT_W(4)) dut (
    .clk_i(clk_i), .start_i(start_i),
    .ID_EX_MemRead_i(ID_EX_MemRead_i), .ID_EX_RTaddr_i(ID_EX_RTaddr_i),
    .IF_ID_RSaddr_i(IF_ID_RSaddr_i), .IF_ID_RTaddr_i(IF_ID_RTaddr_i),
    .Branch_i(Branch_i), .Eq_i(Eq_i), .Jump_i(Jump_i),
    .EX_MEM_MemRead_i(EX_MEM_MemRead_i), .EX_MEM_MemWrite_i(EX_MEM_MemWrite_i),
    .dmem_ack_i(dmem_ack_i), .dmem_req_o(dmem_req_o), .PCWrite_o(PCWrite_o),
    .IF_ID_Write_o(IF_ID_Write_o), .IF_Flush_o(IF_Flush_o), .NOP_o(NOP_o),
    .ID_EX_Write_o(ID_EX_Write_o), .EX_MEM_Write_o(EX_MEM_Write_o),
    .MEM_WB_Bubble_o(MEM_WB_Bubble_o), .fault_o(fault_o), .stall_cnt_o(stall_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clr_in();
    ID_EX_MemRead_i   = 1'b0;
    ID_EX_RTaddr_i    = 5'd0;
    IF_ID_RSaddr_i    = 5'd0;
    IF_ID_RTaddr_i    = 5'd0;
    Branch_i          = 1'b0;
    Eq_i              = 1'b0;
    Jump_i            = 1'b0;
    EX_MEM_MemRead_i  = 1'b0;
    EX_MEM_MemWrite_i = 1'b0;
    dmem_ack_i        = 1'b0;
  endtask

  // One clock: queue the expectation, compare at the falling edge, advance past the next rising edge.
  task automatic cyc(input string tag, input logic [8:0] e);
    logic [12:0] ent;
    logic [8:0]  got;
    if (!start_i) exp_stall = 4'd0;
    exp_q.push_back({e, exp_stall});
    @(negedge clk_i);
    ent = exp_q.pop_front();
    got = {dmem_req_o, PCWrite_o, IF_ID_Write_o, IF_Flush_o, NOP_o,
           ID_EX_Write_o, EX_MEM_Write_o, MEM_WB_Bubble_o, fault_o};
    check_eq({tag, "/ctl"}, 32'(got), 32'(ent[12:4]));
    check_eq({tag, "/cnt"}, 32'(stall_cnt_o), 32'(ent[3:0]));
    if (start_i && !e[7] && exp_stall != 4'hF) exp_stall = exp_stall + 4'd1;
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    start_i = 1'b0;
    clr_in();
    @(posedge clk_i);
    #1;
    cyc("reset_idle", E_RST);
    ID_EX_MemRead_i = 1'b1; ID_EX_RTaddr_i = 5'd5; IF_ID_RSaddr_i = 5'd5; Jump_i = 1'b1;
    cyc("reset_busy", E_RST);
    clr_in();
    start_i = 1'b1;
    cyc("run_idle", E_IDLE);

    // Load-use on rs, then on rt
    ID_EX_MemRead_i = 1'b1; ID_EX_RTaddr_i = 5'd5; IF_ID_RSaddr_i = 5'd5;
    cyc("lu_rs", E_LU);
    clr_in();
    cyc("lu_after", E_IDLE);
    ID_EX_MemRead_i = 1'b1; ID_EX_RTaddr_i = 5'd7; IF_ID_RSaddr_i = 5'd3; IF_ID_RTaddr_i = 5'd7;
    cyc("lu_rt", E_LU);
    ID_EX_MemRead_i = 1'b0;
    cyc("no_load", E_IDLE);

    // Register 0 never stalls; load-use beats a taken branch
    ID_EX_MemRead_i = 1'b1; ID_EX_RTaddr_i = 5'd0; IF_ID_RSaddr_i = 5'd0; IF_ID_RTaddr_i = 5'd0;
    cyc("reg0", E_IDLE);
    ID_EX_RTaddr_i = 5'd5; IF_ID_RTaddr_i = 5'd5; Branch_i = 1'b1; Eq_i = 1'b1;
    cyc("lu_vs_br", E_LU);
    ID_EX_MemRead_i = 1'b0;
    cyc("br_taken", E_XFER);
    Eq_i = 1'b0;
    cyc("br_not_taken", E_IDLE);
    clr_in();
    Jump_i = 1'b1;
    cyc("jump", E_XFER);
    clr_in();

    // Memory access acknowledged in the request cycle
    EX_MEM_MemWrite_i = 1'b1; dmem_ack_i = 1'b1;
    cyc("mem_fast", E_REQ);
    clr_in();

    // Load acked on the fourth cycle: three freezes, hazards suppressed while frozen
    EX_MEM_MemRead_i = 1'b1;
    ID_EX_MemRead_i = 1'b1; ID_EX_RTaddr_i = 5'd9; IF_ID_RSaddr_i = 5'd9; Jump_i = 1'b1;
    cyc("wait_req", E_FRZ);
    EX_MEM_MemRead_i = 1'b0;
    cyc("wait_1", E_FRZ);
    cyc("wait_2", E_FRZ);
    clr_in();
    dmem_ack_i = 1'b1;
    cyc("wait_ack", E_REQ);
    clr_in();
    cyc("wait_done", E_IDLE);

    // Timeout, sticky fault and counter saturation
    start_i = 1'b0;
    cyc("rst_pre_to", E_RST);
    start_i = 1'b1;
    EX_MEM_MemWrite_i = 1'b1;
    cyc("to_req", E_FRZ);
    EX_MEM_MemWrite_i = 1'b0;
    for (int i = 0; i < 4; i++) cyc($sformatf("to_wait%0d", i), E_FRZ);
    dmem_ack_i = 1'b1; EX_MEM_MemRead_i = 1'b1;
    for (int i = 0; i < 15; i++) cyc($sformatf("fault%0d", i), E_FLT);
    start_i = 1'b0;
    cyc("fault_rst", E_RST);
    clr_in();
    start_i = 1'b1;
    cyc("post_fault", E_IDLE);

    // Reset asserted mid-wait aborts the access
    EX_MEM_MemRead_i = 1'b1;
    cyc("mw_req", E_FRZ);
    cyc("mw_wait", E_FRZ);
    start_i = 1'b0;
    cyc("mw_rst", E_RST);
    clr_in();
    start_i = 1'b1;
    cyc("mw_after0", E_IDLE);
    cyc("mw_after1", E_IDLE);

    check_eq("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 64: maximum data-memory wait cycles before fault.
REQ-002 SHALL have parameter CNT_W, default 16: width of the stall counter.
REQ-003 SHALL have ports, one per line:
- clk_i  in  1  single clock; all state updates on rising edge.
- start_i  in  1  asynchronous active-low reset.
- ID_EX_MemRead_i  in  1  the instruction in EX is a load.
- ID_EX_RTaddr_i  in  5  load destination register in EX.
- IF_ID_RSaddr_i  in  5  rs field of the instruction in ID.
- IF_ID_RTaddr_i  in  5  rt field of the instruction in ID.
- Branch_i  in  1  ID instruction is a branch.
- Eq_i  in  1  ID register comparator equal.
- Jump_i  in  1  ID instruction is a jump.
- EX_MEM_MemRead_i  in  1  MEM stage performs a load.
- EX_MEM_MemWrite_i  in  1  MEM stage performs a store.
- dmem_ack_i  in  1  data memory completes the access this cycle.
- dmem_req_o  out  1  data memory request.
- PCWrite_o  out  1  PC load enable.
- IF_ID_Write_o  out  1  IF/ID load enable.
- IF_Flush_o  out  1  IF/ID loads an all-zero instruction.
- NOP_o  out  1  ID/EX control fields load zero.
- ID_EX_Write_o  out  1  ID/EX load enable.
- EX_MEM_Write_o  out  1  EX/MEM load enable.
- MEM_WB_Bubble_o  out  1  MEM/WB loads RegWrite=0, MemtoReg=0.
- fault_o  out  1  data memory timeout; sticky.
- stall_cnt_o  out  CNT_W  count of cycles with PCWrite_o=0.

Function
REQ-004 SHALL implement FSM states RUN, MEM_WAIT and FAULT; the state after reset is RUN.
REQ-005 In RUN with no other event, SHALL drive PCWrite_o, IF_ID_Write_o, ID_EX_Write_o and EX_MEM_Write_o to 1, and every other control output to 0.
REQ-006 Load-use: SHALL detect load-use when ID_EX_MemRead_i=1, ID_EX_RTaddr_i!=0, and ID_EX_RTaddr_i equals IF_ID_RSaddr_i or IF_ID_RTaddr_i.
- Response, same cycle, combinational: PCWrite_o=0, IF_ID_Write_o=0, NOP_o=1.
REQ-007 Control transfer: SHALL detect a taken transfer when Branch_i&Eq_i or Jump_i.
- Response, same cycle: IF_Flush_o=1 with PCWrite_o=1.
REQ-008 When load-use and a taken transfer occur in the same cycle, load-use SHALL win: IF_Flush_o=0, and the transfer is re-evaluated next cycle.
REQ-009 In RUN, dmem_req_o SHALL equal EX_MEM_MemRead_i|EX_MEM_MemWrite_i; if dmem_ack_i=1 in the same cycle, there SHALL be no stall and the state SHALL remain RUN.
REQ-010 In RUN, a request with dmem_ack_i=0 SHALL cause a transition to MEM_WAIT.
- In that request cycle, SHALL freeze combinationally: PCWrite_o, IF_ID_Write_o, ID_EX_Write_o and EX_MEM_Write_o=0; MEM_WB_Bubble_o=1.
REQ-011 In MEM_WAIT, dmem_req_o SHALL stay 1 and the freeze SHALL hold.
- On the cycle dmem_ack_i=1: freeze released combinationally (RUN outputs for that cycle), next state RUN.
REQ-012 Freeze (REQ-010/011/014) SHALL override load-use and transfer.
- NOP_o=0 and IF_Flush_o=0 while frozen; load-use and transfer are re-evaluated after release.
REQ-013 SHALL keep a wait counter: cleared on entering MEM_WAIT, incremented each MEM_WAIT cycle without ack.
- When the counter reaches TIMEOUT-1 without ack, SHALL transition to FAULT.
REQ-014 FAULT SHALL be terminal until reset, with fault_o=1, dmem_req_o=0 and the freeze held.
REQ-015 stall_cnt_o SHALL increment on every cycle with PCWrite_o=0 outside reset, saturating at all-ones.
REQ-016 Inputs SHALL NOT be registered; the only state is the FSM, the wait counter and stall_cnt_o.

Reset
REQ-017 While start_i=0, SHALL force state RUN and clear the wait counter and stall_cnt_o asynchronously.
REQ-018 While start_i=0, SHALL drive all write enables to 0 and NOP_o, IF_Flush_o, MEM_WB_Bubble_o, dmem_req_o and fault_o to 0.
REQ-019 Reset asserted during MEM_WAIT or FAULT SHALL abort immediately; the first cycle after release SHALL be RUN with no request carried over.

Verification
REQ-020 Load-use: ID_EX_MemRead_i=1, ID_EX_RTaddr_i=5, IF_ID_RSaddr_i=5 -> that cycle PCWrite_o=0, IF_ID_Write_o=0, NOP_o=1; stall_cnt_o +1.
REQ-021 Register 0: ID_EX_RTaddr_i=0 and IF_ID_RTaddr_i=0 with load -> no stall; together with Branch_i=Eq_i=1, load-use on rt=5 -> IF_Flush_o=0.
REQ-022 Memory wait: EX_MEM_MemRead_i=1, ack after 3 cycles -> 3 freeze cycles, MEM_WB_Bubble_o=1 each, then RUN; stall_cnt_o +3.
REQ-023 Timeout: TIMEOUT=4, store with no ack -> FAULT after 4 wait cycles; fault_o=1, dmem_req_o=0 held until start_i=0.
REQ-024 Reset mid-wait: start_i low in MEM_WAIT -> outputs zeroed immediately; after release state RUN, stall_cnt_o=0.
REQ-025 Saturation: CNT_W=4, hold a freeze for 20 cycles -> stall_cnt_o stops at 15.
